// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Memory-side responder for the CPU data port. Captures one load/store
//   request in IDLE, waits WAIT_CYCLES states, then performs the access and
//   pulses ready for one cycle.
//
//   Parameters:
//     ADDR_W      word-address width (RAM depth 2**ADDR_W words)
//     DATA_W      data word width
//     WAIT_CYCLES wait states before the response (0..15)
//   Ports:
//     clk              system clock, rising edge
//     rst              asynchronous reset, active low
//     req              request valid (sampled only in IDLE)
//     we               1 = store, 0 = load
//     addr             word address
//     wdata            store data
//     ready            one-cycle completion strobe
//     data_mem_to_cpu  last load result, held until the next load completes
//     busy             high while a request is in flight
module data_mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic [DATA_W-1:0] data_mem_to_cpu,
  output logic              busy
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              commit;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // commit marks the WAIT->RESP edge, where the memory access happens
  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    case (state)
      S_IDLE: if (req) state_nxt = S_WAIT;
      S_WAIT: begin
        if (cnt == '0) begin
          state_nxt = S_RESP;
          commit    = 1'b1;
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt             <= '0;
      we_q            <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      ready           <= 1'b0;
      data_mem_to_cpu <= '0;
    end else begin
      ready <= commit;
      if (state == S_IDLE && req) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
        cnt     <= WAIT_INIT;
      end else if (state == S_WAIT && cnt != '0) begin
        cnt <= cnt - 4'd1;
      end
      if (commit && !we_q) data_mem_to_cpu <= mem[addr_q];
    end
  end

  // RAM has no reset so contents survive it; reset forces IDLE, which
  // blocks commit, so an uncommitted store is dropped.
  always_ff @(posedge clk) begin
    if (commit && we_q) mem[addr_q] <= wdata_q;
  end

  assign busy = (state != S_IDLE);

endmodule
